// File: rtl/jtframe_multi_wait.sv
// jtframe_multi_wait: multi-channel CPU cen gate with ROM/device wait
// states and recovery of cen pulses lost to ROM waits.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cen_in          raw cen per channel
//   cen_out         gated/recovered cen per channel (combinational)
//   gate            1 = channel may run this cycle (combinational)
//   rec_en          1 = channel bus idle, recovery pulses allowed
//   dev_busy        shared-memory busy; stalls from it are not recovered
//   rom_cs, rom_ok  SDRAM ROM chip select / data valid per channel
//   flush           synchronous clear of all miss counters
//   miss            miss counter per channel, channel i at [i*CNTW +: CNTW]
//   stall_cnt       (JTFRAME_WAIT_STATS_EN only) dropped cen_in count,
//                   16 bits per channel, wraps, cleared by rst only
module jtframe_multi_wait #(
    parameter int               NCH      = 2,
    parameter int               CNTW     = 4,
    parameter int               RECGAP   = 1,
    parameter logic [NCH-1:0]   RECOVERY = {NCH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      cen_in,
    output logic [NCH-1:0]      cen_out,
    output logic [NCH-1:0]      gate,
    input  logic [NCH-1:0]      rec_en,
    input  logic [NCH-1:0]      dev_busy,
    input  logic [NCH-1:0]      rom_cs,
    input  logic [NCH-1:0]      rom_ok,
    input  logic                flush,
    output logic [NCH*CNTW-1:0] miss
`ifdef JTFRAME_WAIT_STATS_EN
    ,
    output logic [NCH*16-1:0]   stall_cnt
`endif
);

    localparam int        GW  = 3;
    localparam logic [GW-1:0] GAP = GW'(RECGAP);

    logic [NCH-1:0]  last_cs_q, last_cs_d;
    logic [NCH-1:0]  locked_q,  locked_d;
    logic [NCH-1:0]  start_q,   start_d;
    logic [CNTW-1:0] miss_q [NCH];
    logic [CNTW-1:0] miss_d [NCH];
    logic [GW-1:0]   gap_q  [NCH];
    logic [GW-1:0]   gap_d  [NCH];

    logic [NCH-1:0]  rom_bad;
    logic [NCH-1:0]  rec;
    logic [NCH-1:0]  lost;

    always_comb begin
        rom_bad   = '0;
        gate      = '0;
        rec       = '0;
        lost      = '0;
        cen_out   = '0;
        miss      = '0;
        last_cs_d = rom_cs;
        locked_d  = '0;
        start_d   = start_q;
        for (int i = 0; i < NCH; i++) begin
            miss_d[i] = miss_q[i];
            gap_d[i]  = gap_q[i];
            // A fresh chip select always costs one cycle, even if ok is high
            rom_bad[i] = rom_cs[i] & (~rom_ok[i] | ~last_cs_q[i]);
            gate[i]    = ~(rom_bad[i] | dev_busy[i] | locked_q[i]);
            rec[i]     = RECOVERY[i] & start_q[i] & (miss_q[i] != '0)
                       & ~cen_in[i] & rec_en[i] & (gap_q[i] >= GAP)
                       & ~flush;
            cen_out[i] = (cen_in[i] & gate[i]) | rec[i];
            // Device stalls are never recovered, even if ROM was also bad
            lost[i]    = cen_in[i] & ~gate[i] & ~dev_busy[i];
            locked_d[i] = rom_bad[i] | dev_busy[i];
            if (~rom_bad[i] & ~dev_busy[i])
                start_d[i] = 1'b1;
            if (cen_out[i])
                gap_d[i] = '0;
            else if (gap_q[i] < GAP)
                gap_d[i] = gap_q[i] + 1'b1;
            if (flush | ~start_q[i])
                miss_d[i] = '0;
            else if (lost[i]) begin
                if (miss_q[i] != '1)
                    miss_d[i] = miss_q[i] + 1'b1;
            end else if (rec[i])
                miss_d[i] = miss_q[i] - 1'b1;
            miss[i*CNTW +: CNTW] = miss_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_cs_q <= '1;
            locked_q  <= '0;
            start_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                miss_q[i] <= '0;
                gap_q[i]  <= GAP;
            end
        end else begin
            last_cs_q <= last_cs_d;
            locked_q  <= locked_d;
            start_q   <= start_d;
            for (int i = 0; i < NCH; i++) begin
                miss_q[i] <= miss_d[i];
                gap_q[i]  <= gap_d[i];
            end
        end
    end

`ifdef JTFRAME_WAIT_STATS_EN
    logic [15:0] stall_q [NCH];
    logic [15:0] stall_d [NCH];

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            stall_d[i] = stall_q[i];
            if (cen_in[i] & ~gate[i])
                stall_d[i] = stall_q[i] + 16'd1;
            stall_cnt[i*16 +: 16] = stall_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst)
                stall_q[i] <= '0;
            else
                stall_q[i] <= stall_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_jtframe_multi_wait.sv
// Randomized bench for jtframe_multi_wait against a cycle-level
// reference model built from the channel rules.
module tb_jtframe_multi_wait;

    localparam int NCH  = 2;
    localparam int CNTW = 2;
    localparam int GAPN = 2;
    localparam logic [NCH-1:0] RECV = 2'b01;
    localparam int MAXM = (1 << CNTW) - 1;
    localparam int NCYC = 4000;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      cen_in, cen_out, gate, rec_en;
    logic [NCH-1:0]      dev_busy, rom_cs, rom_ok;
    logic                flush;
    logic [NCH*CNTW-1:0] miss;
`ifdef JTFRAME_WAIT_STATS_EN
    logic [NCH*16-1:0]   stall_cnt;
`endif

    jtframe_multi_wait #(
        .NCH(NCH), .CNTW(CNTW), .RECGAP(GAPN), .RECOVERY(RECV)
    ) dut (
        .clk(clk), .rst(rst),
        .cen_in(cen_in), .cen_out(cen_out), .gate(gate),
        .rec_en(rec_en), .dev_busy(dev_busy),
        .rom_cs(rom_cs), .rom_ok(rom_ok),
        .flush(flush), .miss(miss)
`ifdef JTFRAME_WAIT_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // reference model state
    bit pcs [NCH];
    bit hold [NCH];
    bit started [NCH];
    int misses [NCH];
    int since [NCH];
    int stalls [NCH];
    int recs [NCH];

    // stimulus state
    int okwait [NCH];
    int busyleft [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            pcs[c] = 1; hold[c] = 0; started[c] = 0;
            misses[c] = 0; since[c] = GAPN; stalls[c] = 0;
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            if ((cyc + c) % 4 == 0)
                cen_in[c] = ($urandom % 8) != 0;
            else
                cen_in[c] = ($urandom % 16) == 0;
            if (!rom_cs[c]) begin
                if ($urandom % 6 == 0) begin
                    rom_cs[c] = 1;
                    okwait[c] = $urandom % 12;
                end
            end else if (okwait[c] == 0) begin
                if ($urandom % 3 == 0)
                    rom_cs[c] = 0;
                else if ($urandom % 4 == 0)
                    okwait[c] = $urandom % 4;
            end else
                okwait[c]--;
            rom_ok[c] = okwait[c] == 0;
            if (busyleft[c] == 0 && $urandom % 25 == 0)
                busyleft[c] = 1 + $urandom % 12;
            dev_busy[c] = busyleft[c] != 0;
            if (busyleft[c] != 0) busyleft[c]--;
            rec_en[c] = ($urandom % 8) != 0;
        end
        flush = ($urandom % 80) == 0;
        rst = ($urandom % 400) == 0;
    endtask

    task automatic step_check();
        bit bad, g, r, eo, cn;
        for (int c = 0; c < NCH; c++) begin
            cn  = cen_in[c];
            bad = rom_cs[c] && (!rom_ok[c] || !pcs[c]);
            g   = !(bad || dev_busy[c] || hold[c]);
            r   = RECV[c] && started[c] && misses[c] > 0 && !cn
                  && rec_en[c] && since[c] >= GAPN && !flush;
            eo  = (cn && g) || r;
            chk($sformatf("gate%0d", c), 32'(gate[c]), 32'(g));
            chk($sformatf("cen_out%0d", c), 32'(cen_out[c]), 32'(eo));
            chk($sformatf("miss%0d", c),
                32'(miss[c*CNTW +: CNTW]), misses[c]);
`ifdef JTFRAME_WAIT_STATS_EN
            chk($sformatf("stall%0d", c),
                32'(stall_cnt[c*16 +: 16]), stalls[c]);
`endif
            if (r) recs[c]++;
            if (!rst) begin
                if (flush || !started[c]) misses[c] = 0;
                else if (cn && !g && !dev_busy[c])
                    misses[c] = (misses[c] < MAXM) ? misses[c] + 1 : MAXM;
                else if (r) misses[c] = misses[c] - 1;
                if (cn && !g) stalls[c] = (stalls[c] + 1) % 65536;
                pcs[c] = rom_cs[c];
                hold[c] = bad || dev_busy[c];
                if (!bad && !dev_busy[c]) started[c] = 1;
                since[c] = eo ? 0 : (since[c] < 100 ? since[c] + 1 : 100);
            end
        end
        if (rst) model_reset();
    endtask

    initial begin
        rst = 1; flush = 0;
        cen_in = '0; rec_en = '0; dev_busy = '0;
        rom_cs = '0; rom_ok = '0;
        for (int c = 0; c < NCH; c++) begin
            okwait[c] = 0; busyleft[c] = 0; recs[c] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        chk("rst_gate", 32'(gate), 32'h3);
        chk("rst_cen_out", 32'(cen_out), 32'h0);
        chk("rst_miss", 32'(miss), 32'h0);
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            cyc = i;
            drive();
            #1;
            step_check();
        end
        // channel 1 has recovery disabled: it must never have recovered
        chk("norec1", 32'(recs[1]), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
